// File: rtl/fifo_synch_param.sv
// fifo_synch_param: parametrised single-clock FIFO with programmable
// almost-full/almost-empty flags, occupancy count, sticky overflow/underflow
// error flags and a selectable first-word-fall-through read mode.
// All status outputs are registered and reflect the occupancy after the edge.
module fifo_synch_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              o_full,
  output logic              o_almost_full,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_clr_err
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);
  // A zero threshold would make almost-full true even when empty.
  localparam logic             AF_RST   = (AF_THRESH == 0) ? 1'b1 : 1'b0;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_r;
  logic              empty_r;
  logic              af_r;
  logic              ae_r;
  logic              ovf_r;
  logic              udf_r;

  logic              rd_ok_s;
  logic              wr_ok_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              ovf_nxt_s;
  logic              udf_nxt_s;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Acceptance, next occupancy and next error flag state.
  always_comb begin
    rd_ok_s = i_rd_en && !empty_r;
    // A write into a full FIFO is still accepted when a read frees a slot.
    wr_ok_s = i_wr_en && (!full_r || rd_ok_s);
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    // A fresh error event outranks a clear request in the same cycle.
    if (i_wr_en && !wr_ok_s) begin
      ovf_nxt_s = 1'b1;
    end else if (i_clr_err) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
    if (i_rd_en && empty_r) begin
      udf_nxt_s = 1'b1;
    end else if (i_clr_err) begin
      udf_nxt_s = 1'b0;
    end else begin
      udf_nxt_s = udf_r;
    end
  end

  // Pointers, occupancy, status flags and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= AF_RST;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
      af_r    <= (count_nxt_s >= CNT_AF);
      ae_r    <= (count_nxt_s <= CNT_AE);
      ovf_r   <= ovf_nxt_s;
      udf_r   <= udf_nxt_s;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= i_data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DATA_W-1:0] data_r;

      // Registered read: head word loaded on an accepted read, held otherwise.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_r <= {DATA_W{1'b0}};
        end else if (rd_ok_s) begin
          data_r <= mem_r[rd_ptr_r];
        end
      end

      assign o_data = data_r;
    end else begin : g_fwft_read
      // Head word presented directly from registered storage while non-empty.
      assign o_data = empty_r ? {DATA_W{1'b0}} : mem_r[rd_ptr_r];
    end
  endgenerate

  assign o_count        = count_r;
  assign o_full         = full_r;
  assign o_empty        = empty_r;
  assign o_almost_full  = af_r;
  assign o_almost_empty = ae_r;
  assign o_overflow     = ovf_r;
  assign o_underflow    = udf_r;

endmodule

// File: tb/tb_fifo_synch_param.sv
// Directed bench for fifo_synch_param: instance a uses registered reads,
// instance b uses first-word-fall-through; both DEPTH=8, AF=6, AE=2.
module tb_fifo_synch_param;

  logic       clk;
  logic       rst_n;

  logic       a_wr, a_rd, a_clr;
  logic [7:0] a_din, a_data;
  logic       a_full, a_af, a_empty, a_ae, a_ovf, a_udf;
  logic [3:0] a_count;

  logic       b_wr, b_rd, b_clr;
  logic [7:0] b_din, b_data;
  logic       b_full, b_af, b_empty, b_ae, b_ovf, b_udf;
  logic [3:0] b_count;

  int n_chk;
  int n_pass;

  fifo_synch_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) u_a (
    .clk(clk), .rst_n(rst_n), .i_wr_en(a_wr), .i_data_in(a_din),
    .o_full(a_full), .o_almost_full(a_af), .i_rd_en(a_rd), .o_data(a_data),
    .o_empty(a_empty), .o_almost_empty(a_ae), .o_count(a_count),
    .o_overflow(a_ovf), .o_underflow(a_udf), .i_clr_err(a_clr)
  );

  fifo_synch_param #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .i_wr_en(b_wr), .i_data_in(b_din),
    .o_full(b_full), .o_almost_full(b_af), .i_rd_en(b_rd), .o_data(b_data),
    .o_empty(b_empty), .o_almost_empty(b_ae), .o_count(b_count),
    .o_overflow(b_ovf), .o_underflow(b_udf), .i_clr_err(b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [7:0] d);
    a_wr = 1'b1; a_din = d; tick(); a_wr = 1'b0;
  endtask

  task automatic a_pop;
    a_rd = 1'b1; tick(); a_rd = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_chk++; if (a_empty !== 1'b1) $display("FAIL reset_empty act=%0b exp=1", a_empty); else n_pass++;
    n_chk++; if (a_ae !== 1'b1) $display("FAIL reset_ae act=%0b exp=1", a_ae); else n_pass++;
    n_chk++; if (a_count !== 4'd0) $display("FAIL reset_count act=%0d exp=0", a_count); else n_pass++;
    n_chk++; if (a_full !== 1'b0) $display("FAIL reset_full act=%0b exp=0", a_full); else n_pass++;
    n_chk++; if (a_af !== 1'b0) $display("FAIL reset_af act=%0b exp=0", a_af); else n_pass++;
    n_chk++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) $display("FAIL reset_err act=%0b%0b exp=00", a_ovf, a_udf); else n_pass++;
    n_chk++; if (a_data !== 8'd0) $display("FAIL reset_data act=%0d exp=0", a_data); else n_pass++;
    n_chk++; if (b_empty !== 1'b1 || b_count !== 4'd0) $display("FAIL reset_b act=%0b/%0d exp=1/0", b_empty, b_count); else n_pass++;
  endtask

  task automatic test_basic_order;
    a_push(8'd10); a_push(8'd20); a_push(8'd30);
    n_chk++; if (a_count !== 4'd3) $display("FAIL basic_count3 act=%0d exp=3", a_count); else n_pass++;
    a_pop();
    n_chk++; if (a_data !== 8'd10) $display("FAIL basic_rd1 act=%0d exp=10", a_data); else n_pass++;
    n_chk++; if (a_count !== 4'd2) $display("FAIL basic_count2 act=%0d exp=2", a_count); else n_pass++;
    a_pop();
    n_chk++; if (a_data !== 8'd20) $display("FAIL basic_rd2 act=%0d exp=20", a_data); else n_pass++;
    n_chk++; if (a_count !== 4'd1) $display("FAIL basic_count1 act=%0d exp=1", a_count); else n_pass++;
    a_pop();
    n_chk++; if (a_data !== 8'd30 || a_empty !== 1'b1) $display("FAIL basic_rd3 act=%0d/%0b exp=30/1", a_data, a_empty); else n_pass++;
  endtask

  task automatic test_fill;
    for (int k = 1; k <= 8; k++) begin
      a_push(8'(k - 1));
      n_chk++; if (a_count !== 4'(k)) $display("FAIL fill_count k=%0d act=%0d exp=%0d", k, a_count, k); else n_pass++;
      n_chk++; if (a_ae !== (k <= 2)) $display("FAIL fill_ae k=%0d act=%0b exp=%0b", k, a_ae, (k <= 2)); else n_pass++;
      n_chk++; if (a_af !== (k >= 6)) $display("FAIL fill_af k=%0d act=%0b exp=%0b", k, a_af, (k >= 6)); else n_pass++;
      n_chk++; if (a_full !== (k == 8)) $display("FAIL fill_full k=%0d act=%0b exp=%0b", k, a_full, (k == 8)); else n_pass++;
    end
    a_push(8'd100);
    n_chk++; if (a_ovf !== 1'b1) $display("FAIL fill_ovf act=%0b exp=1", a_ovf); else n_pass++;
    n_chk++; if (a_count !== 4'd8) $display("FAIL fill_ovf_count act=%0d exp=8", a_count); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      a_pop();
      n_chk++; if (a_data !== 8'(k)) $display("FAIL fill_drain k=%0d act=%0d exp=%0d", k, a_data, k); else n_pass++;
    end
    n_chk++; if (a_udf !== 1'b0) $display("FAIL fill_udf_early act=%0b exp=0", a_udf); else n_pass++;
    a_pop();
    n_chk++; if (a_udf !== 1'b1) $display("FAIL fill_udf act=%0b exp=1", a_udf); else n_pass++;
    n_chk++; if (a_data !== 8'd7 || a_count !== 4'd0) $display("FAIL fill_udf_hold act=%0d/%0d exp=7/0", a_data, a_count); else n_pass++;
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    n_chk++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) $display("FAIL fill_clr act=%0b%0b exp=00", a_ovf, a_udf); else n_pass++;
  endtask

  task automatic test_simultaneous;
    for (int k = 0; k < 8; k++) a_push(8'(40 + k));
    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'd55; tick(); a_wr = 1'b0; a_rd = 1'b0;
    n_chk++; if (a_count !== 4'd8 || a_full !== 1'b1) $display("FAIL sim_full_count act=%0d/%0b exp=8/1", a_count, a_full); else n_pass++;
    n_chk++; if (a_data !== 8'd40) $display("FAIL sim_full_data act=%0d exp=40", a_data); else n_pass++;
    n_chk++; if (a_ovf !== 1'b0) $display("FAIL sim_full_ovf act=%0b exp=0", a_ovf); else n_pass++;
    for (int k = 1; k < 8; k++) begin
      a_pop();
      n_chk++; if (a_data !== 8'(40 + k)) $display("FAIL sim_drain k=%0d act=%0d exp=%0d", k, a_data, 40 + k); else n_pass++;
    end
    a_pop();
    n_chk++; if (a_data !== 8'd55 || a_empty !== 1'b1) $display("FAIL sim_last act=%0d/%0b exp=55/1", a_data, a_empty); else n_pass++;
    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'd9; tick(); a_wr = 1'b0; a_rd = 1'b0;
    n_chk++; if (a_count !== 4'd1 || a_empty !== 1'b0) $display("FAIL sim_empty_count act=%0d/%0b exp=1/0", a_count, a_empty); else n_pass++;
    n_chk++; if (a_udf !== 1'b1) $display("FAIL sim_empty_udf act=%0b exp=1", a_udf); else n_pass++;
    n_chk++; if (a_data !== 8'd55) $display("FAIL sim_empty_hold act=%0d exp=55", a_data); else n_pass++;
    a_pop();
    n_chk++; if (a_data !== 8'd9 || a_count !== 4'd0) $display("FAIL sim_empty_rd act=%0d/%0d exp=9/0", a_data, a_count); else n_pass++;
    a_clr = 1'b1; tick(); a_clr = 1'b0;
  endtask

  task automatic test_fwft_wrap;
    logic [7:0] w;
    for (int i = 0; i < 20; i++) begin
      w = 8'(i * 13 + 5);
      b_wr = 1'b1; b_din = w; tick(); b_wr = 1'b0;
      n_chk++; if (b_empty !== 1'b0 || b_data !== w) $display("FAIL fwft_head i=%0d act=%0d exp=%0d", i, b_data, w); else n_pass++;
      b_rd = 1'b1; tick(); b_rd = 1'b0;
      n_chk++; if (b_empty !== 1'b1 || b_count !== 4'd0) $display("FAIL fwft_pop i=%0d act=%0b/%0d exp=1/0", i, b_empty, b_count); else n_pass++;
    end
    b_wr = 1'b1;
    b_din = 8'd11; tick();
    b_din = 8'd22; tick();
    b_din = 8'd33; tick();
    b_wr = 1'b0;
    n_chk++; if (b_data !== 8'd11 || b_count !== 4'd3) $display("FAIL fwft_burst_head act=%0d/%0d exp=11/3", b_data, b_count); else n_pass++;
    b_rd = 1'b1; tick();
    n_chk++; if (b_data !== 8'd22) $display("FAIL fwft_next1 act=%0d exp=22", b_data); else n_pass++;
    tick();
    n_chk++; if (b_data !== 8'd33) $display("FAIL fwft_next2 act=%0d exp=33", b_data); else n_pass++;
    tick(); b_rd = 1'b0;
    n_chk++; if (b_empty !== 1'b1 || b_udf !== 1'b0) $display("FAIL fwft_drained act=%0b/%0b exp=1/0", b_empty, b_udf); else n_pass++;
  endtask

  task automatic test_reset_mid;
    for (int k = 1; k <= 5; k++) a_push(8'(k));
    a_pop();
    a_pop();
    a_pop();
    a_pop();
    a_pop();
    a_pop();
    n_chk++; if (a_udf !== 1'b1) $display("FAIL mid_pre_udf act=%0b exp=1", a_udf); else n_pass++;
    for (int k = 1; k <= 5; k++) a_push(8'(k + 60));
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (a_count !== 4'd0 || a_empty !== 1'b1) $display("FAIL mid_async act=%0d/%0b exp=0/1", a_count, a_empty); else n_pass++;
    n_chk++; if (a_udf !== 1'b0 || a_data !== 8'd0) $display("FAIL mid_async_clr act=%0b/%0d exp=0/0", a_udf, a_data); else n_pass++;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    a_wr = 1'b1; a_din = 8'd77;
    tick(); a_wr = 1'b0;
    a_pop();
    n_chk++; if (a_data !== 8'd77 || a_empty !== 1'b1) $display("FAIL mid_after act=%0d/%0b exp=77/1", a_data, a_empty); else n_pass++;
  endtask

  task automatic test_clr_err;
    a_pop();
    for (int k = 0; k < 8; k++) a_push(8'(k));
    a_push(8'd99);
    n_chk++; if (a_ovf !== 1'b1 || a_udf !== 1'b1) $display("FAIL clr_both act=%0b%0b exp=11", a_ovf, a_udf); else n_pass++;
    a_wr = 1'b1; a_din = 8'd98; a_clr = 1'b1; tick(); a_wr = 1'b0; a_clr = 1'b0;
    n_chk++; if (a_ovf !== 1'b1 || a_udf !== 1'b0) $display("FAIL clr_race act=%0b%0b exp=10", a_ovf, a_udf); else n_pass++;
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    n_chk++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) $display("FAIL clr_pulse act=%0b%0b exp=00", a_ovf, a_udf); else n_pass++;
    a_pop();
    n_chk++; if (a_data !== 8'd0 || a_count !== 4'd7) $display("FAIL clr_intact act=%0d/%0d exp=0/7", a_data, a_count); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b0; a_din = 8'd0;
    b_wr = 1'b0; b_rd = 1'b0; b_clr = 1'b0; b_din = 8'd0;
    test_reset();
    test_basic_order();
    test_fill();
    test_simultaneous();
    test_fwft_wrap();
    test_reset_mid();
    test_clr_err();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
